deconcatinator: RTL and testbench

DECONCATINATOR -- requirements
Module: deconcatinator

---
 rtl/deconcatinator_if.sv | 26 ++
 rtl/deconcatinator.sv | 85 ++++++++
 tb/tb_deconcatinator.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/deconcatinator_if.sv
// Stream bundle between a packed-word producer and a chunk consumer, with flush and status.
// The design sits on the slave modport; the producer/consumer side uses master.
interface deconcatinator_if #(
    parameter int IN_W  = 72,
    parameter int OUT_W = 50
) ();
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             flush;
    logic [7:0]       fill_level;
    logic             busy;

    modport master (
        output in_data, in_valid, out_ready, flush,
        input  in_ready, out_data, out_valid, fill_level, busy
    );

    modport slave (
        input  in_data, in_valid, out_ready, flush,
        output in_ready, out_data, out_valid, fill_level, busy
    );
endinterface

// File: rtl/deconcatinator.sv
// Re-slices IN_W-bit words into OUT_W-bit chunks, LSB first; 1-cycle latency from accept to chunk valid.
// Input stalls when the accumulator lacks room after this cycle's pop; output holds stable while out_ready is low.
module deconcatinator #(
    parameter int IN_W  = 72,
    parameter int OUT_W = 50,
    parameter int BUF_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    deconcatinator_if.slave   bus
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [7:0] OUT_W8 = 8'(OUT_W);
    localparam logic [7:0] IN_W8  = 8'(IN_W);
    localparam logic [7:0] ROOM8  = 8'(BUF_W - IN_W);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [BUF_W-1:0] r_buf;
    logic [7:0]       r_cnt;

    logic             w_out_valid;
    logic             w_in_ready;
    logic             w_pop;
    logic             w_push;
    logic [7:0]       w_c1;
    logic [7:0]       w_cnt_nxt;
    logic [BUF_W-1:0] w_b1;
    logic [BUF_W-1:0] w_in_ext;
    logic [BUF_W-1:0] w_buf_nxt;

    assign w_out_valid = (r_cnt >= OUT_W8) | ((r_state == FLUSH) & (r_cnt != 8'd0));
    assign w_pop       = w_out_valid & bus.out_ready;

    // A residual flush pop drains whatever is left, so clamp instead of wrapping below zero.
    assign w_c1 = w_pop ? ((r_cnt >= OUT_W8) ? (r_cnt - OUT_W8) : 8'd0) : r_cnt;

    assign w_in_ready = (r_state == RUN) & (w_c1 <= ROOM8);
    assign w_push     = bus.in_valid & w_in_ready;

    assign w_b1      = w_pop ? (r_buf >> OUT_W) : r_buf;
    assign w_in_ext  = BUF_W'(bus.in_data);
    assign w_buf_nxt = w_b1 | (w_push ? (w_in_ext << w_c1) : {BUF_W{1'b0}});
    assign w_cnt_nxt = w_c1 + (w_push ? IN_W8 : 8'd0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (bus.flush) w_state_nxt = FLUSH;
            FLUSH:   if (w_cnt_nxt == 8'd0) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= {BUF_W{1'b0}};
            r_cnt <= 8'd0;
        end else begin
            r_buf <= w_buf_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Bits above cnt are always zero, so a short flush chunk comes out already zero-padded.
    assign bus.out_data   = r_buf[OUT_W-1:0];
    assign bus.out_valid  = w_out_valid;
    assign bus.in_ready   = w_in_ready;
    assign bus.fill_level = r_cnt;
    assign bus.busy       = (r_cnt != 8'd0) | (r_state == FLUSH);

endmodule

// File: tb/tb_deconcatinator.sv
module tb_deconcatinator;

    localparam int IN_W  = 72;
    localparam int OUT_W = 50;
    localparam int BUF_W = 128;

    logic clk;
    logic rst_n;

    deconcatinator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    deconcatinator #(.IN_W(IN_W), .OUT_W(OUT_W), .BUF_W(BUF_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_pops   = 0;

    // Reference model: the accepted bit stream as a plain FIFO of bits plus a flushing flag.
    bit               exp_bits[$];
    bit               m_flush;
    bit               prev_stall;
    logic [OUT_W-1:0] prev_data;
    int               sz;
    bit               exp_valid;
    bit               exp_rdy;
    bit               pop;
    logic [OUT_W-1:0] exp_chunk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    function automatic logic [IN_W-1:0] rnd72();
        return IN_W'({$urandom(), $urandom(), $urandom()});
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_bits.delete();
            m_flush    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            sz        = exp_bits.size();
            exp_valid = (sz >= OUT_W) || (m_flush && sz != 0);
            chk("out_valid", 128'(bus.out_valid), 128'(exp_valid));
            chk("fill_level", 128'(bus.fill_level), 128'(sz));
            chk("busy", 128'(bus.busy), 128'((sz != 0) || m_flush));
            pop     = exp_valid && bus.out_ready;
            exp_rdy = !m_flush && ((sz - (pop ? OUT_W : 0)) <= (BUF_W - IN_W));
            chk("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
            if (prev_stall) chk("stall_stable", 128'(bus.out_data), 128'(prev_data));
            prev_stall = exp_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (pop) begin
                exp_chunk = '0;
                for (int i = 0; i < OUT_W; i++)
                    if (exp_bits.size() > 0) exp_chunk[i] = exp_bits.pop_front();
                chk("chunk", 128'(bus.out_data), 128'(exp_chunk));
                n_pops++;
            end
            if (bus.in_valid && exp_rdy)
                for (int i = 0; i < IN_W; i++) exp_bits.push_back(bus.in_data[i]);
            if (!m_flush) m_flush = bus.flush;
            else if (exp_bits.size() == 0) m_flush = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves in_valid high so consecutive calls stream back-to-back.
    task automatic send(input logic [IN_W-1:0] w);
        bit acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        step();
        if (!acc) timeout("send");
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        pulse_flush();
        for (int i = 0; i < 50; i++) begin
            if (!bus.busy) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) timeout("drain");
    endtask

    logic [IN_W-1:0] w1, w2, w3;
    int n0;

    initial begin
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        #2;
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_fill", 128'(bus.fill_level), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        step();
        rst_n = 1'b1;
        step();

        // Single word
        bus.out_ready = 1'b1;
        send(72'd70);
        bus.in_valid = 1'b0;
        chk("single_valid", 128'(bus.out_valid), 128'(1));
        chk("single_data", 128'(bus.out_data), 128'(50'd70));
        step();
        chk("single_fill", 128'(bus.fill_level), 128'(22));
        drain();

        // Backpressure, then simultaneous push and pop at cnt=72
        w1 = rnd72();
        w2 = rnd72();
        bus.out_ready = 1'b0;
        send(w1);
        chk("bp_fill", 128'(bus.fill_level), 128'(72));
        bus.in_data = w2;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
            chk("bp_fill_hold", 128'(bus.fill_level), 128'(72));
            chk("bp_data_hold", 128'(bus.out_data), 128'(w1[49:0]));
        end
        bus.out_ready = 1'b1;
        #1;
        chk("pp_in_ready", 128'(bus.in_ready), 128'(1));
        send(w2);
        bus.in_valid = 1'b0;
        chk("pp_fill", 128'(bus.fill_level), 128'(94));
        chk("pp_order", 128'(bus.out_data), 128'({w2[27:0], w1[71:50]}));
        drain();

        // Streaming
        n0 = n_pops;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 25; i++) send(rnd72());
        bus.in_valid = 1'b0;
        repeat (20) step();
        chk("stream_chunks", 128'(n_pops - n0), 128'(36));
        chk("stream_fill", 128'(bus.fill_level), 128'(0));

        // Flush residual
        w1 = rnd72();
        bus.out_ready = 1'b0;
        send(w1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("res_fill", 128'(bus.fill_level), 128'(22));
        bus.out_ready = 1'b0;
        pulse_flush();
        chk("res_valid", 128'(bus.out_valid), 128'(1));
        chk("res_data", 128'(bus.out_data), 128'({28'b0, w1[71:50]}));
        bus.out_ready = 1'b1;
        step();
        chk("res_fill0", 128'(bus.fill_level), 128'(0));
        chk("res_busy", 128'(bus.busy), 128'(0));
        chk("res_in_ready", 128'(bus.in_ready), 128'(1));

        // Reset mid-flush at fill_level 66
        w1 = rnd72(); w2 = rnd72(); w3 = rnd72();
        bus.out_ready = 1'b0;
        send(w1);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
        send(w2);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
        send(w3);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
        chk("pre_rst_fill", 128'(bus.fill_level), 128'(66));
        pulse_flush();
        chk("pre_rst_busy", 128'(bus.busy), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(bus.out_valid), 128'(0));
        chk("mid_rst_fill", 128'(bus.fill_level), 128'(0));
        chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("mid_rst_busy", 128'(bus.busy), 128'(0));
        step();
        rst_n = 1'b1;
        step();
        bus.out_ready = 1'b1;
        send(72'd48);
        bus.in_valid = 1'b0;
        chk("post_rst_valid", 128'(bus.out_valid), 128'(1));
        chk("post_rst_data", 128'(bus.out_data), 128'(50'd48));
        drain();

        // Random traffic with occasional flushes
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom % 3) != 0;
            bus.in_data   = rnd72();
            bus.out_ready = ($urandom % 4) != 0;
            bus.flush     = ($urandom % 50) == 0;
            step();
        end
        bus.flush = 1'b0;
        drain();
        chk("final_fill", 128'(bus.fill_level), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
